// File: rtl/vram_fetch_unit.sv
// vram_fetch_unit: video-side read master for the VRAM port.
//
// Once per scanline it walks a contiguous run of BytesPerLine bytes, starting at
// i_line_base, through an asynchronous SRAM using the active-low ce/oe/we
// handshake. Each byte costs one address cycle plus WaitStates output-enable
// cycles. Bytes go into a small FIFO and from there into a pixel shifter that the
// raster timing generator drains one pixel per i_pix_req.
//
// Optional feature macro: VRAM_FETCH_2BPP_EN
//   undefined : 1 bit per pixel, 8 pixels per byte, MSB first
//   defined   : 2 bits per pixel, 4 pixels per byte, bits [7:6] first
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_b       synchronous active-low reset
//   i_line_start  one-cycle pulse: flush everything and start a new line
//   i_line_base   first byte address, sampled with i_line_start
//   i_pix_req     consumer takes the current pixel this cycle
//   o_pixel       current pixel (top bits of the shifter), 0 when not valid
//   o_pix_valid   o_pixel holds a fetched pixel
//   o_underrun    sticky: a mid-line request found no valid pixel
//   o_busy        line fetch in progress
//   o_addr        VRAM address
//   o_ce_b        VRAM chip enable, active low
//   o_oe_b        VRAM output enable, active low
//   o_we_b        VRAM write enable, always high
//   i_data        VRAM read data

module vram_fetch_unit #(
    parameter int unsigned AddrWidth    = 16,
    parameter int unsigned BytesPerLine = 40,
    parameter int unsigned WaitStates   = 2,
    parameter int unsigned FifoDepth    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_b,
    input  logic                 i_line_start,
    input  logic [AddrWidth-1:0] i_line_base,
    input  logic                 i_pix_req,
`ifdef VRAM_FETCH_2BPP_EN
    output logic [1:0]           o_pixel,
`else
    output logic                 o_pixel,
`endif
    output logic                 o_pix_valid,
    output logic                 o_underrun,
    output logic                 o_busy,
    output logic [AddrWidth-1:0] o_addr,
    output logic                 o_ce_b,
    output logic                 o_oe_b,
    output logic                 o_we_b,
    input  logic [7:0]           i_data
);

`ifdef VRAM_FETCH_2BPP_EN
    localparam int unsigned PixW = 2;
`else
    localparam int unsigned PixW = 1;
`endif
    localparam int unsigned LinePix = BytesPerLine * 8 / PixW;
    localparam int unsigned PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW    = PtrW + 1;
    localparam logic [3:0]  Step    = 4'(PixW);

    typedef enum logic [1:0] {StIdle, StAddr, StWait, StHold} state_e;

    // Fetch FSM state
    state_e                 state_q, state_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [7:0]             byte_cnt_q, byte_cnt_d;
    logic                   busy_q, busy_d;
    logic                   push;

    // Byte FIFO
    logic [7:0]             fifo_mem [FifoDepth];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic                   pop;

    // Pixel shifter; bits_q counts bits still to be emitted from shift_q
    logic [7:0]             shift_q, shift_d;
    logic [3:0]             bits_q, bits_d;
    logic [11:0]            cons_q, cons_d;
    logic                   underrun_q, underrun_d;
    logic                   pix_valid;
    logic                   consume;

    assign pix_valid = (bits_q != 4'd0);
    assign consume   = i_pix_req && pix_valid;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        busy_d     = busy_q;
        push       = 1'b0;

        if (i_line_start) begin
            state_d    = StAddr;
            wait_cnt_d = '0;
            addr_d     = i_line_base;
            byte_cnt_d = '0;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                StIdle: ;
                StAddr: begin
                    state_d    = StWait;
                    wait_cnt_d = '0;
                end
                StWait: begin
                    if (wait_cnt_q == 8'(WaitStates - 1)) begin
                        push       = 1'b1;
                        addr_d     = addr_q + AddrWidth'(1);
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (byte_cnt_q + 8'd1 == 8'(BytesPerLine)) begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end else if (fifo_cnt_q <= CntW'(FifoDepth - 2)) begin
                            state_d = StAddr;
                        end else begin
                            // This push may fill the FIFO; park until a slot frees.
                            state_d = StHold;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                StHold: begin
                    if (fifo_cnt_q != CntW'(FifoDepth)) begin
                        state_d = StAddr;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO and pixel shifter
    // ------------------------------------------------------------------
    // Pop uses the registered count, so a byte pushed this edge reaches the
    // shifter no earlier than the next edge.
    assign pop = (fifo_cnt_q != '0) && ((bits_q == 4'd0) || (i_pix_req && (bits_q == Step)));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        shift_d    = shift_q;
        bits_d     = bits_q;
        cons_d     = cons_q;
        underrun_d = underrun_q;

        if (i_line_start) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            shift_d    = '0;
            bits_d     = '0;
            cons_d     = '0;
            underrun_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                shift_d  = fifo_mem[rd_ptr_q];
                bits_d   = 4'd8;
            end else if (consume) begin
                shift_d = shift_q << PixW;
                bits_d  = bits_q - Step;
            end
            fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);

            if (consume) begin
                cons_d = cons_q + 12'd1;
            end
            // Mid-line only: the initial fill latency before the first pixel
            // is taken is not an underrun, and neither is anything past the
            // end of the line.
            if (i_pix_req && !pix_valid && (cons_q != 12'd0) && (cons_q < 12'(LinePix))) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            shift_q    <= '0;
            bits_q     <= '0;
            cons_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            shift_q    <= shift_d;
            bits_q     <= bits_d;
            cons_q     <= cons_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_pixel     = pix_valid ? shift_q[7 -: PixW] : '0;
    assign o_pix_valid = pix_valid;
    assign o_underrun  = underrun_q;
    assign o_busy      = busy_q;
    assign o_addr      = addr_q;
    assign o_ce_b      = !((state_q == StAddr) || (state_q == StWait));
    assign o_oe_b      = (state_q != StWait);
    assign o_we_b      = 1'b1;

endmodule

// File: tb/tb_vram_fetch_unit.sv
// Directed bench for vram_fetch_unit. Instance A uses the default parameters;
// instance B uses BytesPerLine=4, WaitStates=8 to show address wrap and a
// fetch rate slower than the pixel rate. Each RAM model answers mem[a] = a[7:0]
// with one cycle of access delay.

module tb_vram_fetch_unit;

`ifdef VRAM_FETCH_2BPP_EN
    localparam int PixW = 2;
`else
    localparam int PixW = 1;
`endif
    localparam int PixPerByte = 8 / PixW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b;

    logic            a_start, a_req, a_valid, a_under, a_busy, a_ce_b, a_oe_b, a_we_b;
    logic [15:0]     a_base, a_addr;
    logic [PixW-1:0] a_pix;
    logic [7:0]      a_data;

    logic            b_start, b_req, b_valid, b_under, b_busy, b_ce_b, b_oe_b, b_we_b;
    logic [15:0]     b_base, b_addr;
    logic [PixW-1:0] b_pix;
    logic [7:0]      b_data;

    vram_fetch_unit u_dut_a (
        .i_clk        (clk),
        .i_rst_b      (rst_b),
        .i_line_start (a_start),
        .i_line_base  (a_base),
        .i_pix_req    (a_req),
        .o_pixel      (a_pix),
        .o_pix_valid  (a_valid),
        .o_underrun   (a_under),
        .o_busy       (a_busy),
        .o_addr       (a_addr),
        .o_ce_b       (a_ce_b),
        .o_oe_b       (a_oe_b),
        .o_we_b       (a_we_b),
        .i_data       (a_data)
    );

    vram_fetch_unit #(
        .AddrWidth    (16),
        .BytesPerLine (4),
        .WaitStates   (8),
        .FifoDepth    (4)
    ) u_dut_b (
        .i_clk        (clk),
        .i_rst_b      (rst_b),
        .i_line_start (b_start),
        .i_line_base  (b_base),
        .i_pix_req    (b_req),
        .o_pixel      (b_pix),
        .o_pix_valid  (b_valid),
        .o_underrun   (b_under),
        .o_busy       (b_busy),
        .o_addr       (b_addr),
        .o_ce_b       (b_ce_b),
        .o_oe_b       (b_oe_b),
        .o_we_b       (b_we_b),
        .i_data       (b_data)
    );

    // Asynchronous RAM with one cycle of access delay.
    always @(posedge clk) begin
        a_data <= (!a_ce_b && !a_oe_b) ? a_addr[7:0] : 8'h00;
        b_data <= (!b_ce_b && !b_oe_b) ? b_addr[7:0] : 8'h00;
    end

    int we_bad = 0;
    always @(negedge clk) begin
        if (a_we_b !== 1'b1 || b_we_b !== 1'b1) we_bad++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PixW-1:0] exp_pix(input logic [15:0] base, input int k);
        logic [15:0] a;
        logic [7:0]  b;
        int          sh;
        a  = base + 16'(k / PixPerByte);
        b  = a[7:0];
        sh = 8 - PixW - (k % PixPerByte) * PixW;
        return PixW'(b >> sh);
    endfunction

    // Address cycles (ce low, oe high) seen during a run, with their cycle index.
    logic [15:0] a_log [64];
    int          a_log_c [64];
    int          a_log_n;
    logic [15:0] b_log [64];
    int          b_log_n;

    task automatic start_a(input logic [15:0] base);
        @(negedge clk);
        a_start = 1'b1;
        a_base  = base;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic start_b(input logic [15:0] base);
        @(negedge clk);
        b_start = 1'b1;
        b_base  = base;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    // Assumes the request line is held high; compares every valid pixel.
    task automatic run_a(input logic [15:0] base, input int npix, input int budget,
                         output int got, output int bad, output int first_v);
        got = 0; bad = 0; first_v = -1; a_log_n = 0;
        for (int c = 0; c < budget && got < npix; c++) begin
            if (!a_ce_b && a_oe_b && a_log_n < 64) begin
                a_log[a_log_n]   = a_addr;
                a_log_c[a_log_n] = c;
                a_log_n++;
            end
            if (a_valid) begin
                if (first_v < 0) first_v = c;
                if (a_pix !== exp_pix(base, got)) bad++;
                got++;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_b(input logic [15:0] base, input int npix, input int budget,
                         output int got, output int bad, output int first_v);
        got = 0; bad = 0; first_v = -1; b_log_n = 0;
        for (int c = 0; c < budget && got < npix; c++) begin
            if (!b_ce_b && b_oe_b && b_log_n < 64) begin
                b_log[b_log_n] = b_addr;
                b_log_n++;
            end
            if (b_valid) begin
                if (first_v < 0) first_v = c;
                if (b_pix !== exp_pix(base, got)) bad++;
                got++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int got, bad, first_v, seq_err, idle_bad;

        rst_b = 1'b0;
        a_start = 1'b0; a_req = 1'b0; a_base = '0;
        b_start = 1'b0; b_req = 1'b0; b_base = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_ce_b", a_ce_b, 1'b1);
        check_eq("rst_oe_b", a_oe_b, 1'b1);
        check_eq("rst_addr", a_addr, 16'h0000);
        check_eq("rst_pixel", a_pix, '0);
        check_eq("rst_valid", a_valid, 1'b0);
        check_eq("rst_underrun", a_under, 1'b0);
        check_eq("rst_busy", a_busy, 1'b0);
        rst_b = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_ce_b !== 1'b1 || a_oe_b !== 1'b1 || b_ce_b !== 1'b1) idle_bad++;
        end
        check_eq("idle_ce_oe_high", idle_bad, 0);

        // Full line, requests held high
        a_req = 1'b1;
        start_a(16'h0100);
        check_eq("line_busy", a_busy, 1'b1);
        check_eq("line_first_addr", a_addr, 16'h0100);
        run_a(16'h0100, 320, 1000, got, bad, first_v);
        check_eq("line_first_valid", first_v, 4);
        check_eq("line_pix_count", got, 320);
        check_eq("line_pix_bad", bad, 0);
        check_eq("line_addr_count", a_log_n, 40);
        check_eq("line_addr_last", a_log[39], 16'h0127);
        check_eq("line_byte_cycles", a_log_c[1] - a_log_c[0], 3);
        seq_err = 0;
        for (int i = 1; i < a_log_n; i++) begin
            if (a_log[i] !== a_log[i-1] + 16'd1) seq_err++;
        end
        check_eq("line_addr_seq", seq_err, 0);
        check_eq("line_end_valid", a_valid, 1'b0);
        check_eq("line_end_pixel", a_pix, '0);
        repeat (3) @(negedge clk);
        check_eq("line_end_busy", a_busy, 1'b0);
        check_eq("line_end_underrun", a_under, 1'b0);

        // No requests: FIFO fills, FSM parks
        a_req = 1'b0;
        start_a(16'h01F0);
        repeat (40) @(negedge clk);
        check_eq("hold_ce_b", a_ce_b, 1'b1);
        check_eq("hold_oe_b", a_oe_b, 1'b1);
        check_eq("hold_addr", a_addr, 16'h01F5);
        check_eq("hold_busy", a_busy, 1'b1);
        check_eq("hold_pixel", a_pix, exp_pix(16'h01F0, 0));
        a_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_pix !== exp_pix(16'h01F0, i) || a_valid !== 1'b1) bad++;
            @(negedge clk);
        end
        a_req = 1'b0;
        check_eq("hold_drain_bad", bad, 0);
        check_eq("hold_next_pixel", a_pix, exp_pix(16'h01F0, 8));
        for (int i = 0; i < 6 && a_ce_b; i++) @(negedge clk);
        check_eq("resume_ce_b", a_ce_b, 1'b0);
        check_eq("resume_addr", a_addr, 16'h01F5);

        // Restart mid-line
        a_req = 1'b1;
        start_a(16'h0100);
        for (int i = 0; i < 300 && a_addr != 16'h010A; i++) @(negedge clk);
        check_eq("reach_byte10", a_addr, 16'h010A);
        start_a(16'h2000);
        check_eq("restart_addr", a_addr, 16'h2000);
        check_eq("restart_valid", a_valid, 1'b0);
        check_eq("restart_underrun", a_under, 1'b0);
        check_eq("restart_busy", a_busy, 1'b1);
        run_a(16'h2000, 16, 100, got, bad, first_v);
        check_eq("restart_pix_count", got, 16);
        check_eq("restart_pix_bad", bad, 0);
        a_req = 1'b0;

        // Instance B: wrap at top of address space, slow fetch -> underrun
        b_req = 1'b1;
        start_b(16'hFFFE);
        run_b(16'hFFFE, 32, 400, got, bad, first_v);
        check_eq("wrap_first_valid", first_v, 10);
        check_eq("wrap_pix_count", got, 32);
        check_eq("wrap_pix_bad", bad, 0);
        check_eq("wrap_addr_count", b_log_n, 4);
        check_eq("wrap_addr0", b_log[0], 16'hFFFE);
        check_eq("wrap_addr1", b_log[1], 16'hFFFF);
        check_eq("wrap_addr2", b_log[2], 16'h0000);
        check_eq("wrap_addr3", b_log[3], 16'h0001);
        check_eq("underrun_set", b_under, 1'b1);
        check_eq("wrap_end_busy", b_busy, 1'b0);
        b_req = 1'b0;
        start_b(16'h0040);
        check_eq("underrun_cleared", b_under, 1'b0);

        // Reset mid-fetch aborts at once
        start_a(16'h3000);
        @(negedge clk);
        check_eq("pre_abort_oe_b", a_oe_b, 1'b0);
        rst_b = 1'b0;
        @(negedge clk);
        check_eq("abort_ce_b", a_ce_b, 1'b1);
        check_eq("abort_oe_b", a_oe_b, 1'b1);
        check_eq("abort_busy", a_busy, 1'b0);
        check_eq("abort_addr", a_addr, 16'h0000);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort_stays_idle", a_ce_b, 1'b1);

        check_eq("we_b_always_high", we_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
